// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 matrix keypad scanner.
// Holds the FSM state encoding, default timing parameters and the key map.
package keypad_pkg;

  localparam int SCAN_DIV_DEF     = 4096;
  localparam int DEBOUNCE_CNT_DEF = 20000;

  typedef enum logic [1:0] {
    SCAN       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } state_t;

  // Physical layout: row 3 carries the E/0/F/D keys rather than */0/#/D.
  function automatic logic [3:0] key_map(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] code;
    code = 4'h0;
    case ({row_idx, col_idx})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'hE;
      4'b11_01: code = 4'h0;
      4'b11_10: code = 4'hF;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a bus of independent asynchronous inputs.
// Each bit is synchronized on its own; no cross-bit coherency is implied.
module sync_2ff #(
  parameter int               WIDTH   = 4,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: rotates an active-low column strobe, debounces the first
// key found and reports one code per press, locking out other keys until release.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV     = SCAN_DIV_DEF,
  parameter int DEBOUNCE_CNT = DEBOUNCE_CNT_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int CNT_MAX = (SCAN_DIV > DEBOUNCE_CNT) ? SCAN_DIV : DEBOUNCE_CNT;
  localparam int CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE_CNT - 1);

  logic [3:0]    rows_s;
  state_t        state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [1:0]    row_q, row_d;
  logic [CW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] db_q, db_d;
  logic [3:0]    cols_q;
  logic [3:0]    code_q, code_d;
  logic          valid_q, valid_d;
  logic          held_q, held_d;
  logic          any_low;
  logic [1:0]    first_row;
  logic          row_sel;

  sync_2ff #(
    .WIDTH  (4),
    .RST_VAL(4'b1111)
  ) u_row_sync (
    .clk  (clk),
    .reset(reset),
    .d_i  (rows),
    .q_o  (rows_s)
  );

  assign any_low = ~&rows_s;
  assign row_sel = rows_s[row_q];

  // Lowest-index low row wins when several rows in the active column are pressed.
  always_comb begin
    first_row = 2'd3;
    if (!rows_s[0])      first_row = 2'd0;
    else if (!rows_s[1]) first_row = 2'd1;
    else if (!rows_s[2]) first_row = 2'd2;
  end

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    dwell_d = dwell_q;
    db_d    = db_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    case (state_q)
      SCAN: begin
        if (dwell_q == DWELL_LAST) begin
          dwell_d = '0;
          if (any_low) begin
            row_d   = first_row;
            db_d    = '0;
            state_d = PRESS_DB;
          end else begin
            col_d = col_q + 2'd1;
          end
        end else begin
          dwell_d = dwell_q + 1'b1;
        end
      end
      PRESS_DB: begin
        if (!row_sel) begin
          if (db_q == DB_LAST) begin
            code_d  = key_map(row_q, col_q);
            valid_d = 1'b1;
            held_d  = 1'b1;
            db_d    = '0;
            state_d = HELD;
          end else begin
            db_d = db_q + 1'b1;
          end
        end else begin
          col_d   = col_q + 2'd1;
          db_d    = '0;
          dwell_d = '0;
          state_d = SCAN;
        end
      end
      HELD: begin
        if (row_sel) begin
          db_d    = '0;
          state_d = RELEASE_DB;
        end
      end
      RELEASE_DB: begin
        if (!row_sel) begin
          db_d    = '0;
          state_d = HELD;
        end else if (db_q == DB_LAST) begin
          held_d  = 1'b0;
          col_d   = col_q + 2'd1;
          db_d    = '0;
          dwell_d = '0;
          state_d = SCAN;
        end else begin
          db_d = db_q + 1'b1;
        end
      end
      default: begin
        state_d = SCAN;
      end
    endcase
  end

  // Column drive is registered so the pins never glitch during a column change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= SCAN;
      col_q   <= 2'd0;
      row_q   <= 2'd0;
      dwell_q <= '0;
      db_q    <= '0;
      cols_q  <= 4'b1110;
      code_q  <= 4'h0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      dwell_q <= dwell_d;
      db_q    <= db_d;
      cols_q  <= ~(4'b0001 << col_d);
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  end

  assign cols      = cols_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural 4x4 key matrix model.
// Runs with SCAN_DIV=4 and DEBOUNCE_CNT=8 so scan and debounce windows stay short.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  rows;
  logic [3:0]  cols;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;

  int          passCount = 0;
  int          failCount = 0;
  int          checkCount = 0;
  int          pulseCount = 0;
  int          doubleCount = 0;
  int          basePulses = 0;
  logic [3:0]  lastCode = 4'h0;
  logic        prevValid = 1'b0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CNT(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rows     (rows),
    .cols     (cols),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Key (r,c) is bit r*4+c of pressed; it pulls row r low while column c is driven low.
  always_comb begin
    rows = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !cols[c]) rows[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (reset && key_valid === 1'b1) begin
      pulseCount++;
      lastCode = key_code;
      if (prevValid) doubleCount++;
    end
    prevValid = key_valid;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [15:0] keys);
    pressed = keys;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic waitHeldLow(input string tag, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (key_held === 1'b0) break;
      tick(1);
    end
    checkOutput(tag, 32'(key_held), 32'd0);
  endtask

  task automatic waitCols(input string tag, input logic [3:0] target, input int maxCycles);
    for (int i = 0; i < maxCycles; i++) begin
      if (cols === target) break;
      tick(1);
    end
    checkOutput(tag, 32'(cols), 32'(target));
  endtask

  initial begin
    applyStimulus(16'h0000);
    tick(2);
    checkOutput("reset_cols", 32'(cols), 32'hE);
    checkOutput("reset_code", 32'(key_code), 32'h0);
    checkOutput("reset_valid", 32'(key_valid), 32'h0);
    checkOutput("reset_held", 32'(key_held), 32'h0);

    reset = 1'b1;
    tick(6);
    checkOutput("prereset_cols", 32'(cols), 32'hD);
    #2 reset = 1'b0;
    #1;
    checkOutput("async_reset_cols", 32'(cols), 32'hE);
    checkOutput("async_reset_held", 32'(key_held), 32'h0);
    @(negedge clk) reset = 1'b1;
    tick(3);
    checkOutput("rot_col0", 32'(cols), 32'hE);
    tick(1);
    checkOutput("rot_col1", 32'(cols), 32'hD);
    tick(4);
    checkOutput("rot_col2", 32'(cols), 32'hB);
    tick(4);
    checkOutput("rot_col3", 32'(cols), 32'h7);
    tick(4);
    checkOutput("rot_wrap", 32'(cols), 32'hE);

    $display("[TB] clean press of 5");
    basePulses = pulseCount;
    applyStimulus(16'h0020);
    tick(40);
    checkOutput("key5_pulses", 32'(pulseCount - basePulses), 32'd1);
    checkOutput("key5_code", 32'(lastCode), 32'h5);
    checkOutput("key5_held", 32'(key_held), 32'd1);
    applyStimulus(16'h0000);
    tick(5);
    checkOutput("key5_held_after_release", 32'(key_held), 32'd1);
    waitHeldLow("key5_release", 20);
    checkOutput("key5_resume_col2", 32'(cols), 32'hB);

    $display("[TB] bounce on press of 3");
    waitCols("bounce_wait_col2", 4'hB, 20);
    basePulses = pulseCount;
    applyStimulus(16'h0004);
    tick(3);
    applyStimulus(16'h0000);
    tick(2);
    checkOutput("bounce_no_pulse", 32'(pulseCount - basePulses), 32'd0);
    applyStimulus(16'h0004);
    tick(1);
    checkOutput("bounce_abort_col3", 32'(cols), 32'h7);
    tick(40);
    checkOutput("key3_pulses", 32'(pulseCount - basePulses), 32'd1);
    checkOutput("key3_code", 32'(lastCode), 32'h3);
    applyStimulus(16'h0000);
    waitHeldLow("key3_release", 20);

    $display("[TB] second key while holding 1");
    basePulses = pulseCount;
    applyStimulus(16'h0001);
    tick(40);
    checkOutput("key1_pulses", 32'(pulseCount - basePulses), 32'd1);
    checkOutput("key1_code", 32'(lastCode), 32'h1);
    applyStimulus(16'h8001);
    tick(30);
    checkOutput("keyD_ignored", 32'(pulseCount - basePulses), 32'd1);
    checkOutput("keyD_code_kept", 32'(key_code), 32'h1);
    checkOutput("keyD_held", 32'(key_held), 32'd1);
    applyStimulus(16'h0000);
    waitHeldLow("key1_release", 20);
    basePulses = pulseCount;
    applyStimulus(16'h2000);
    tick(40);
    checkOutput("key0_pulses", 32'(pulseCount - basePulses), 32'd1);
    checkOutput("key0_code", 32'(lastCode), 32'h0);
    applyStimulus(16'h0000);
    waitHeldLow("key0_release", 20);

    $display("[TB] release bounce on F");
    basePulses = pulseCount;
    applyStimulus(16'h4000);
    tick(40);
    checkOutput("keyF_pulses", 32'(pulseCount - basePulses), 32'd1);
    checkOutput("keyF_code", 32'(key_code), 32'hF);
    basePulses = pulseCount;
    applyStimulus(16'h0000);
    tick(3);
    applyStimulus(16'h4000);
    tick(1);
    applyStimulus(16'h0000);
    tick(8);
    checkOutput("relbounce_still_held", 32'(key_held), 32'd1);
    waitHeldLow("relbounce_release", 10);
    checkOutput("relbounce_no_pulse", 32'(pulseCount - basePulses), 32'd0);

    $display("[TB] multi-row press on column 0");
    basePulses = pulseCount;
    applyStimulus(16'h0110);
    tick(40);
    checkOutput("multirow_pulses", 32'(pulseCount - basePulses), 32'd1);
    checkOutput("multirow_code", 32'(lastCode), 32'h4);

    $display("[TB] reset while key held");
    #2 reset = 1'b0;
    #1;
    checkOutput("midhold_reset_held", 32'(key_held), 32'd0);
    checkOutput("midhold_reset_code", 32'(key_code), 32'h0);
    @(negedge clk) reset = 1'b1;
    basePulses = pulseCount;
    tick(40);
    checkOutput("fresh_pulses", 32'(pulseCount - basePulses), 32'd1);
    checkOutput("fresh_code", 32'(lastCode), 32'h4);
    checkOutput("fresh_held", 32'(key_held), 32'd1);
    applyStimulus(16'h0000);
    waitHeldLow("fresh_release", 20);

    checkOutput("single_cycle_valid", 32'(doubleCount), 32'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
